// File: rtl/pb_conditioner.sv
// pb_conditioner: synchronizes and debounces four push buttons, with optional sticky press flags cleared by processor reads
module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit LATCH_MODE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] pb_raw,
  input  logic       rd_strobe,
  output logic [3:0] pushbuttons,
  output logic [3:0] pb_level,
  output logic [3:0] pb_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {STABLE0, COUNT_UP, STABLE1, COUNT_DOWN} state_t;
  state_t state_q [4];
  state_t state_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0] s1, s2, sticky, level_d, press_d, sticky_d;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = pb_level[i];
      press_d[i] = 1'b0;
      case (state_q[i])
        STABLE0: if (s2[i]) begin
          state_d[i] = COUNT_UP;
          cnt_d[i]   = CW'(1);
        end
        COUNT_UP: if (!s2[i]) begin
          state_d[i] = STABLE0;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == LAST) begin
          state_d[i] = STABLE1;
          cnt_d[i]   = '0;
          level_d[i] = 1'b1;
          press_d[i] = 1'b1;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
        STABLE1: if (!s2[i]) begin
          state_d[i] = COUNT_DOWN;
          cnt_d[i]   = CW'(1);
        end
        default: if (s2[i]) begin
          state_d[i] = STABLE1;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == LAST) begin
          state_d[i] = STABLE0;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      endcase
    end
    // a press arriving with a read still lands in the flags
    sticky_d = (sticky & {4{~rd_strobe}}) | press_d;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      sticky      <= '0;
      pb_level    <= '0;
      pb_press    <= '0;
      pushbuttons <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= STABLE0;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1          <= pb_raw;
      s2          <= s1;
      sticky      <= sticky_d;
      pb_level    <= level_d;
      pb_press    <= press_d;
      pushbuttons <= LATCH_MODE ? sticky_d : level_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
endmodule

// File: doc/pb_conditioner.md
# pb_conditioner

Input conditioner that sits directly upstream of the 4-bit microprocessor and drives its `pushbuttons` input bus. Each of the four raw board buttons is synchronized into the `clock` domain and debounced by a per-bit counter FSM. The block presents either the debounced levels or sticky "pressed since last read" flags to the processor, and clears the flags when the processor executes an input read.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized cycles of disagreement needed to accept a new level. Legal range is 2..65535. The counter width is derived internally.
- `LATCH_MODE`, default 0: selects what drives `pushbuttons`. 0 = debounced level. 1 = sticky press flags.

Ports:
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears every register immediately.
- `pb_raw` in 4: raw, asynchronous, bouncing button inputs.
- `rd_strobe` in 1: processor input-read strobe, the IN buffer enable. Level-sensitive, sampled on `clock`.
- `pushbuttons` out 4: bus to the processor, selected by `LATCH_MODE`.
- `pb_level` out 4: debounced button levels.
- `pb_press` out 4: one-cycle pulse per bit on each debounced 0→1 transition.

## Operation
- **Synchronizer:** a 2-flop synchronizer per bit, `s1 <= pb_raw`, `s2 <= s1`. Only `s2` is used downstream.
- **Per-bit FSM states:** STABLE0, COUNT_UP, STABLE1, COUNT_DOWN.
  - STABLE0, `s2`=1: go to COUNT_UP, count=1.
  - COUNT_UP, `s2`=1:
    - count<DEBOUNCE_CYCLES: count+1.
    - count reaches DEBOUNCE_CYCLES on this edge: go to STABLE1, set level=1, clear count, set `pb_press`.
  - COUNT_UP, `s2`=0: return to STABLE0, count=0. The glitch is rejected.
  - STABLE1 and COUNT_DOWN are symmetric with polarity reversed. A release never produces a `pb_press` pulse.
- **Counter width:** the counter never exceeds DEBOUNCE_CYCLES and does not wrap.
- **Bit independence:** the four bits are fully independent. Simultaneous transitions on several bits are each handled on their own schedule.
- **Sticky flags (`sticky[i]`):**
  - Set on the edge where `pb_press[i]` is generated.
  - All four cleared on every edge where `rd_strobe`=1.
  - If set and clear hit the same bit on the same edge, set wins and the press is never lost.
- **Output select:**
  - `LATCH_MODE`=0: `pushbuttons` = `pb_level`.
  - `LATCH_MODE`=1: `pushbuttons` = `sticky`.
- **Registered outputs:** all outputs are registered. No combinational path from `pb_raw` or `rd_strobe` to any output.

## Timing
- **Reset values:**
  - Outputs: `pushbuttons`=0000, `pb_level`=0000, `pb_press`=0000.
  - Internal state: s1, s2, counters and sticky flags = 0; all FSMs in STABLE0.
- **Press latency:** `pb_raw[i]` changes and is held, and is captured by edge E1 into s1.
  - s2 changes at E2.
  - `pb_level[i]` changes at edge E(2+DEBOUNCE_CYCLES).
- **Press pulse:** `pb_press[i]` is high for exactly the one cycle following that edge.
- **Sticky visibility:** `sticky[i]` becomes visible on `pushbuttons` at the same edge as the `pb_level` rise.
- **Glitch rejection:** any `s2` pulse shorter than DEBOUNCE_CYCLES cycles causes no output change.
- **Clear timing:** the `rd_strobe` clear takes effect at the sampling edge, so `pushbuttons` reads 0 in the following cycle. The processor reads the pre-clear value during the strobe cycle.
- **Reset mid-debounce:** reset asserted mid-count aborts the debounce. After release, a still-held button needs the full 2+DEBOUNCE_CYCLES edges again.
- **Held button:** a button held indefinitely yields exactly one `pb_press` pulse.

## Test plan
- **Reset values:** assert reset with `pb_raw`=1111 → all outputs 0000 immediately. Deassert → `pb_level`=1111 at the 2+DEBOUNCE_CYCLES-th edge (18 with default).
- **Clean press and release, DEBOUNCE_CYCLES=4:**
  - `pb_raw[0]` 0→1 before E1 → `pb_level`=0001 after E6, `pb_press`=0001 for one cycle only.
  - Release → `pb_level`=0000 after 6 further edges, no press pulse.
- **Bounce rejection, DEBOUNCE_CYCLES=4:** `pb_raw[2]` high for 3 cycles, low 1, high 2, low → `pb_level` stays 0000 and `pb_press` never pulses.
- **Latch mode, LATCH_MODE=1:**
  - Press and release button 1 → `pushbuttons`=0010 persists after release.
  - `rd_strobe` for one cycle → `pushbuttons`=0000 the next cycle.
- **Set/clear collision:** `rd_strobe`=1 on the same edge that `pb_press[3]` is generated → `pushbuttons`=1000 afterwards.
- **Mid-debounce reset:**
  - Reset pulsed at E4 of a held press, DEBOUNCE_CYCLES=4 → no `pb_press` before E6 after release.
  - The press completes after the full 6 edges from release.
- **Bit independence:** raw 0101 and 1010 staggered by 2 cycles → each bit's level rises exactly 2+D edges after its own raw change.
